// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUop,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       illegal;
    } ctl_t;

    state_e     state_q, state_d;
    logic [5:0] op_q;
    state_e     dec_target;
    logic       dec_known;
    ctl_t       ctl;
    ctl_t       ctl_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Opcode dispatch; only consulted while in DECODE.
    always_comb begin
        dec_target = FETCH;
        dec_known  = 1'b1;
        case (opcode)
            OP_LW:    dec_target = MEMADR;
            OP_SW:    dec_target = MEMADR;
            OP_RTYPE: dec_target = RTYPEEX;
            OP_BEQ:   dec_target = BEQEX;
            OP_ADDI:  dec_target = ADDIEX;
            OP_J:     dec_target = JEX;
            default:  dec_known  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE:  state_d = dec_target;
            MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ctl = '0;
        unique case (state_q)
            FETCH: begin
                ctl.mem_read = 1'b1;
                ctl.src_b    = 2'b01;
                ctl.ir_write = mem_ready;
                ctl.pc_write = mem_ready;
            end
            DECODE: begin
                ctl.src_b   = 2'b11;
                ctl.illegal = ~dec_known;
            end
            MEMADR: begin
                ctl.src_a = 1'b1;
                ctl.src_b = 2'b10;
            end
            MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            RTYPEEX: begin
                ctl.src_a  = 1'b1;
                ctl.alu_op = 2'b10;
            end
            RTYPEWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            BEQEX: begin
                ctl.src_a         = 1'b1;
                ctl.alu_op        = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_src        = 2'b01;
            end
            ADDIEX: begin
                ctl.src_a = 1'b1;
                ctl.src_b = 2'b10;
            end
            ADDIWB: ctl.reg_write = 1'b1;
            JEX: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = 2'b10;
            end
            default: ctl = '0;
        endcase
    end

    // Reset silences every strobe at once, even before the state clears.
    assign ctl_out = reset ? '0 : ctl;

    assign ALUop       = ctl_out.alu_op;
    assign ALUSrcA     = ctl_out.src_a;
    assign ALUSrcB     = ctl_out.src_b;
    assign PCSource    = ctl_out.pc_src;
    assign PCWrite     = ctl_out.pc_write;
    assign PCWriteCond = ctl_out.pc_write_cond;
    assign IorD        = ctl_out.iord;
    assign MemRead     = ctl_out.mem_read;
    assign MemWrite    = ctl_out.mem_write;
    assign IRWrite     = ctl_out.ir_write;
    assign MemtoReg    = ctl_out.mem_to_reg;
    assign RegDst      = ctl_out.reg_dst;
    assign RegWrite    = ctl_out.reg_write;
    assign illegal_op  = ctl_out.illegal;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level reference model
// expands each instruction into expected per-cycle state and control words.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       illegal_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .illegal_op(illegal_op), .state(state)
    );

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Control word: ALUop,SrcA,SrcB,PCSrc,PCW,PCWC,IorD,MR,MW,IRW,MtR,RD,RW,ILL
    function automatic logic [16:0] spec_word(int st, bit rdy, bit ill);
        logic [16:0] w;
        case (st)
            0:  w = {2'b00, 1'b0, 2'b01, 2'b00, rdy, 1'b0, 1'b0, 1'b1,
                     1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0};
            1:  w = {2'b00, 1'b0, 2'b11, 2'b00, 9'b0, ill};
            2:  w = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0_0;
            3:  w = 17'b00_0_00_00_0_0_1_1_0_0_0_0_0_0;
            4:  w = 17'b00_0_00_00_0_0_0_0_0_0_1_0_1_0;
            5:  w = 17'b00_0_00_00_0_0_1_0_1_0_0_0_0_0;
            6:  w = 17'b10_1_00_00_0_0_0_0_0_0_0_0_0_0;
            7:  w = 17'b00_0_00_00_0_0_0_0_0_0_0_1_1_0;
            8:  w = 17'b01_1_00_01_0_1_0_0_0_0_0_0_0_0;
            9:  w = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0_0;
            10: w = 17'b00_0_00_00_0_0_0_0_0_0_0_0_1_0;
            11: w = 17'b00_0_00_10_1_0_0_0_0_0_0_0_0_0;
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b001000, 6'b000010};
    endfunction

    task automatic push_exp(int st, bit rdy, bit ill);
        logic [3:0] s4;
        s4 = st[3:0];
        exp_q.push_back({s4, spec_word(st, rdy, ill)});
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(21'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic run_instr(logic [5:0] op, int sf, int sm, int abort_at);
        step_t sch[$];
        int path[$];
        case (op)
            6'b100011: path = '{2, 3, 4};
            6'b101011: path = '{2, 5};
            6'b000000: path = '{6, 7};
            6'b000100: path = '{8};
            6'b001000: path = '{9, 10};
            6'b000010: path = '{11};
            default:   path = '{};
        endcase
        for (int i = 0; i < sf; i++) sch.push_back('{0, 1'b0});
        sch.push_back('{0, 1'b1});
        sch.push_back('{1, 1'($urandom)});
        foreach (path[k]) begin
            if (path[k] == 3 || path[k] == 5) begin
                for (int i = 0; i < sm; i++) sch.push_back('{path[k], 1'b0});
                sch.push_back('{path[k], 1'b1});
            end else begin
                sch.push_back('{path[k], 1'($urandom)});
            end
        end
        foreach (sch[i]) begin
            if (i == abort_at) begin
                do_reset(1 + int'($urandom_range(0, 1)));
                return;
            end
            opcode = (sch[i].st == 1) ? op : 6'($urandom);
            mem_ready = sch[i].rdy;
            push_exp(sch[i].st, sch[i].rdy, sch[i].st == 1 && !is_legal(op));
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            logic [20:0] a;
            e = exp_q.pop_front();
            a = {state, ALUop, ALUSrcA, ALUSrcB, PCSource, PCWrite,
                 PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, illegal_op};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctl t=%0t rst=%0b state=%0d word=%b required state=%0d word=%b",
                         $time, reset, a[20:17], a[16:0], e[20:17], e[16:0]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] op;
        int sf, sm, ab;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011,
                      6'b000100, 6'b001000, 6'b000010};
        reset = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        #1;
        do_reset(2);
        run_instr(6'b100011, 0, 0, -1);
        run_instr(6'b000000, 0, 0, -1);
        run_instr(6'b000100, 0, 0, -1);
        run_instr(6'b101011, 0, 3, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(6'b001000, 1, 0, -1);
        run_instr(6'b000010, 2, 0, -1);
        run_instr(6'b100011, 1, 2, -1);
        run_instr(6'b101011, 0, 3, 5);
        run_instr(6'b100011, 0, 3, 4);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 5)];
            sf = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            sm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(op, sf, sm, ab);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain pending=%0d required=0", exp_q.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
